// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry stream decoder: record field layout, error codes, FSM states.
// Optional duplicate-record checking in the top is enabled by defining TELEMETRY_DUP_CHECK_EN.
package telemetry_pkg;

  localparam int USB_MSB = 15;
  localparam int USB_LSB = 12;
  localparam int CTL_MSB = 11;
  localparam int CTL_LSB = 8;
  localparam int BLK_MSB = 7;
  localparam int BLK_LSB = 0;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_ODD   = 2'd2;
  localparam logic [1:0] ERR_LONG  = 2'd3;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    ST_HI   = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic        last;
    logic [2:0]  index;
    logic [15:0] data;
  } rec_t;

  // Records travel low byte first on the wire.
  function automatic logic [15:0] pack_record(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/axis_skid.sv
// One-entry valid/ready holding register; the payload stays stable while the consumer stalls.
// Accepts a new word whenever the register is empty or is being drained in the same cycle.
module axis_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/telemetry_decoder.sv
// Reassembles 16-bit telemetry records from an 8-bit AXI-S byte stream and checks frame framing.
// Define TELEMETRY_DUP_CHECK_EN to flag records identical to the previously emitted one.
module telemetry_decoder
  import telemetry_pkg::*;
#(
  parameter int RECORDS = 8,
  parameter int CWIDTH  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [7:0]        s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [2:0]        m_index,
  output logic [3:0]        m_usb_state,
  output logic [3:0]        m_ctl_state,
  output logic [7:0]        m_blk_state,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [CWIDTH-1:0] rec_count_o,
  output logic [CWIDTH-1:0] err_count_o
);

  localparam logic [2:0] LAST_IDX = 3'(RECORDS - 1);

  state_e            state_q, state_d;
  logic [7:0]        lo_q, lo_d;
  logic [2:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CWIDTH-1:0] rec_count_q, rec_count_d;
  logic [CWIDTH-1:0] err_count_q, err_count_d;

  rec_t rec_in;
  rec_t out_rec;
  logic rec_load;
  logic skid_ready;
  logic s_fire;
  logic m_fire;
  logic dup_hit;

  // A high byte may only be taken when the output register can absorb the finished record.
  assign s_tready = (state_q != ST_HI) || skid_ready;
  assign s_fire   = s_tvalid && s_tready;
  assign m_fire   = m_tvalid && m_tready;

`ifdef TELEMETRY_DUP_CHECK_EN
  logic [15:0] last_rec_q, last_rec_d;
  logic        last_rec_valid_q, last_rec_valid_d;

  assign dup_hit          = m_fire && last_rec_valid_q && (out_rec.data == last_rec_q);
  assign last_rec_d       = m_fire ? out_rec.data : last_rec_q;
  assign last_rec_valid_d = last_rec_valid_q || m_fire;
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    idx_d        = idx_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    rec_load     = 1'b0;
    rec_in.last  = 1'b0;
    rec_in.index = idx_q;
    rec_in.data  = pack_record(s_tdata, lo_q);

    if (s_fire) begin
      case (state_q)
        ST_LO: begin
          if (s_tlast) begin
            err_d      = 1'b1;
            err_code_d = ERR_ODD;
            idx_d      = '0;
          end else begin
            lo_d    = s_tdata;
            state_d = ST_HI;
          end
        end
        ST_HI: begin
          rec_load = 1'b1;
          state_d  = ST_LO;
          if (idx_q == LAST_IDX) begin
            rec_in.last = 1'b1;
            idx_d       = '0;
            if (!s_tlast) begin
              err_d      = 1'b1;
              err_code_d = ERR_LONG;
              state_d    = ST_DROP;
            end
          end else if (s_tlast) begin
            rec_in.last = 1'b1;
            idx_d       = '0;
            err_d       = 1'b1;
            err_code_d  = ERR_SHORT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        ST_DROP: begin
          if (s_tlast) begin
            state_d = ST_LO;
            idx_d   = '0;
          end
        end
        default: state_d = ST_LO;
      endcase
    end

    // A framing error in the same cycle keeps its more informative code.
    if (dup_hit && !err_d) begin
      err_d      = 1'b1;
      err_code_d = ERR_NONE;
    end

    rec_count_d = rec_count_q;
    if (m_fire && (rec_count_q != {CWIDTH{1'b1}})) begin
      rec_count_d = rec_count_q + 1'b1;
    end
    err_count_d = err_count_q;
    if (err_d && (err_count_q != {CWIDTH{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_LO;
      lo_q             <= '0;
      idx_q            <= '0;
      err_q            <= 1'b0;
      err_code_q       <= ERR_NONE;
      rec_count_q      <= '0;
      err_count_q      <= '0;
`ifdef TELEMETRY_DUP_CHECK_EN
      last_rec_q       <= '0;
      last_rec_valid_q <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      lo_q             <= lo_d;
      idx_q            <= idx_d;
      err_q            <= err_d;
      err_code_q       <= err_code_d;
      rec_count_q      <= rec_count_d;
      err_count_q      <= err_count_d;
`ifdef TELEMETRY_DUP_CHECK_EN
      last_rec_q       <= last_rec_d;
      last_rec_valid_q <= last_rec_valid_d;
`endif
    end
  end

  axis_skid #(
    .WIDTH($bits(rec_t))
  ) u_out_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (rec_load),
    .in_ready (skid_ready),
    .in_data  (rec_in),
    .out_valid(m_tvalid),
    .out_ready(m_tready),
    .out_data (out_rec)
  );

  assign m_tlast     = out_rec.last;
  assign m_index     = out_rec.index;
  assign m_usb_state = out_rec.data[USB_MSB:USB_LSB];
  assign m_ctl_state = out_rec.data[CTL_MSB:CTL_LSB];
  assign m_blk_state = out_rec.data[BLK_MSB:BLK_LSB];
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign rec_count_o = rec_count_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_telemetry_decoder.sv
// Scoreboard bench for telemetry_decoder: a byte-level reference model queues expected records,
// a negedge monitor pops and compares them on every output handshake.
module tb_telemetry_decoder;

  localparam int RECORDS = 8;
  localparam int CWIDTH  = 16;

  logic              clock;
  logic              reset_n;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [7:0]        s_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [2:0]        m_index;
  logic [3:0]        m_usb_state;
  logic [3:0]        m_ctl_state;
  logic [7:0]        m_blk_state;
  logic              err_o;
  logic [1:0]        err_code_o;
  logic [CWIDTH-1:0] rec_count_o;
  logic [CWIDTH-1:0] err_count_o;

  telemetry_decoder #(
    .RECORDS(RECORDS),
    .CWIDTH (CWIDTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tdata    (s_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_index    (m_index),
    .m_usb_state(m_usb_state),
    .m_ctl_state(m_ctl_state),
    .m_blk_state(m_blk_state),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .rec_count_o(rec_count_o),
    .err_count_o(err_count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks   = 0;
  int n_errors   = 0;
  int exp_recs   = 0;
  int exp_errs   = 0;
  int err_pulses = 0;
  logic [1:0]  exp_code = 2'd0;
  logic [19:0] sb_q[$];

  // Reference model state: phase 0 = low byte next, 1 = high byte next, 2 = dropping
  int         ph    = 0;
  int         m_idx = 0;
  logic [7:0] m_lo  = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph         = 0;
    m_idx      = 0;
    m_lo       = 8'h00;
    exp_recs   = 0;
    exp_errs   = 0;
    exp_code   = 2'd0;
    err_pulses = 0;
    sb_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    logic lastf;
    case (ph)
      0: begin
        if (l) begin
          exp_errs++;
          exp_code = 2'd2;
          m_idx    = 0;
        end else begin
          m_lo = d;
          ph   = 1;
        end
      end
      1: begin
        lastf = l || (m_idx == RECORDS - 1);
        sb_q.push_back({lastf, m_idx[2:0], d, m_lo});
        exp_recs++;
        ph = 0;
        if (m_idx == RECORDS - 1) begin
          m_idx = 0;
          if (!l) begin
            exp_errs++;
            exp_code = 2'd3;
            ph       = 2;
          end
        end else if (l) begin
          exp_errs++;
          exp_code = 2'd1;
          m_idx    = 0;
        end else begin
          m_idx++;
        end
      end
      default: begin
        if (l) begin
          ph    = 0;
          m_idx = 0;
        end
      end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int waited;
    waited   = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    @(negedge clock);
    while (!s_tready && waited < 200) begin
      waited++;
      @(negedge clock);
    end
    if (!s_tready) begin
      check("send_timeout", {31'b0, s_tready}, 32'd1);
      #1;
    end else begin
      @(posedge clock);
      model_accept(d, l);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] start, input int n, input int tlast_at);
    for (int i = 1; i <= n; i++) begin
      send_byte(start + 8'(i - 1), i == tlast_at);
    end
  endtask

  task automatic drain_and_check(input string tag);
    repeat (4) @(posedge clock);
    #1;
    check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    check({tag, "_rec_count"}, rec_count_o, exp_recs);
    check({tag, "_err_count"}, err_count_o, exp_errs);
    check({tag, "_err_pulses"}, err_pulses, exp_errs);
    check({tag, "_err_code"}, err_code_o, exp_code);
  endtask

  // Output monitor: one line per completed record handshake
  always @(negedge clock) begin
    logic [19:0] obs;
    logic [19:0] exp;
    if (reset_n) begin
      if (err_o) err_pulses++;
      if (m_tvalid && m_tready) begin
        obs = {m_tlast, m_index, m_usb_state, m_ctl_state, m_blk_state};
        if (sb_q.size() == 0) begin
          check("unexpected_record", sb_q.size(), 32'd1);
        end else begin
          exp = sb_q.pop_front();
          $display("record idx=%0d last=%0d data=%04h", m_index, m_tlast, obs[15:0]);
          check("record", {12'b0, obs}, {12'b0, exp});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int rc_before;
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_m_tvalid", m_tvalid, 32'd0);
    check("reset_err_o", err_o, 32'd0);
    check("reset_err_code", err_code_o, 32'd0);
    check("reset_rec_count", rec_count_o, 32'd0);
    check("reset_err_count", err_count_o, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Clean 16-byte frame; first record is visible the cycle after its high byte
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check("lat_m_tvalid", m_tvalid, 32'd1);
    check("lat_index", m_index, 32'd0);
    check("lat_usb", m_usb_state, 32'd0);
    check("lat_ctl", m_ctl_state, 32'd2);
    check("lat_blk", m_blk_state, 32'h01);
    check("lat_tlast", m_tlast, 32'd0);
    for (int i = 3; i <= 16; i++) send_byte(8'(i), i == 16);
    drain_and_check("clean");

    // Short frame: tlast on byte 6
    send_frame(8'h01, 6, 6);
    check("short_err_o", err_o, 32'd1);
    check("short_err_code", err_code_o, 32'd1);
    @(posedge clock);
    #1;
    check("short_err_pulse_end", err_o, 32'd0);
    drain_and_check("short");
    send_frame(8'h01, 16, 16);
    drain_and_check("after_short");

    // Odd frame: tlast on byte 5, a low byte
    send_frame(8'h01, 5, 5);
    check("odd_err_o", err_o, 32'd1);
    check("odd_err_code", err_code_o, 32'd2);
    drain_and_check("odd");
    send_frame(8'h01, 16, 16);
    drain_and_check("after_odd");

    // Long frame: 20 bytes, tlast only on byte 20
    send_frame(8'h01, 16, 0);
    check("long_err_o", err_o, 32'd1);
    check("long_err_code", err_code_o, 32'd3);
    for (int i = 17; i <= 20; i++) send_byte(8'(i), i == 20);
    drain_and_check("long");
    send_frame(8'h01, 16, 16);
    drain_and_check("after_long");

    // Consumer stall mid-frame
    rc_before = int'(rec_count_o);
    fork
      send_frame(8'h21, 16, 16);
      begin
        repeat (4) @(posedge clock);
        #1 m_tready = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("stall_s_tready", s_tready, 32'd0);
        check("stall_m_tvalid", m_tvalid, 32'd1);
        repeat (2) @(posedge clock);
        #1 m_tready = 1'b1;
      end
    join
    drain_and_check("stall");
    check("stall_rec_delta", int'(rec_count_o) - rc_before, 32'd8);

    // Two identical consecutive records
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    for (int i = 5; i <= 16; i++) send_byte(8'(i), i == 16);
`ifdef TELEMETRY_DUP_CHECK_EN
    exp_errs++;
    exp_code = 2'd0;
`endif
    drain_and_check("dup");

    // Asynchronous reset after a lone low byte
    send_byte(8'h33, 1'b0);
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    check("areset_m_tvalid", m_tvalid, 32'd0);
    check("areset_rec_count", rec_count_o, 32'd0);
    check("areset_err_count", err_count_o, 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    send_frame(8'h01, 16, 16);
    drain_and_check("after_areset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
